spi_cmd_rx: RTL and testbench



---
 rtl/spi_cmd_rx_pkg.sv | 20 ++
 rtl/sync_bit.sv | 25 ++
 rtl/spi_cmd_rx.sv | 125 ++++++++++++
 tb/tb_spi_cmd_rx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_rx_pkg.sv
// rtl/spi_cmd_rx_pkg.sv - frame layout constants and receiver state encoding
package spi_cmd_rx_pkg;

    localparam int SPI_FRAME_BITS = 64;
    localparam int SPI_CNT_W      = 7;

    localparam int SPI_CMD_MSB  = 63;
    localparam int SPI_CMD_LSB  = 48;
    localparam int SPI_ADDR_MSB = 47;
    localparam int SPI_ADDR_LSB = 40;
    localparam int SPI_DATA_MSB = 39;
    localparam int SPI_DATA_LSB = 0;

    typedef enum logic [1:0] {
        SRX_IDLE  = 2'd0,
        SRX_SHIFT = 2'd1,
        SRX_CHECK = 2'd2
    } srx_state_t;

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop single-bit synchroniser with selectable reset value
module sync_bit #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the asynchronous input through STAGES flops
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ff <= {STAGES{RESET_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_cmd_rx.sv
// rtl/spi_cmd_rx.sv - oversampled SPI mode-0 command frame deserialiser
module spi_cmd_rx
    import spi_cmd_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = SPI_FRAME_BITS
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        spi_cs_n,
    output logic [15:0] spi_cmd_r,
    output logic [7:0]  spi_addr_r,
    output logic [39:0] spi_data_r,
    output logic        spi_data_valid_r,
    output logic        frame_err,
    output logic        busy
);

    localparam logic [SPI_CNT_W-1:0] CNT_FULL = SPI_CNT_W'(FRAME_BITS);
    localparam logic [SPI_CNT_W-1:0] CNT_MAX  = SPI_CNT_W'(FRAME_BITS + 1);

    logic sclk_s, mosi_s, cs_s;
    logic sclk_d, cs_d;
    logic sclk_rise, cs_fall, cs_rise;

    srx_state_t                state;
    logic [FRAME_BITS-1:0]     shift_reg;
    logic [SPI_CNT_W-1:0]      bit_cnt;
    logic                      chk_ok;
    logic                      chk_err;

    sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .resetn(resetn), .d(spi_sclk), .q(sclk_s)
    );

    sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .resetn(resetn), .d(spi_mosi), .q(mosi_s)
    );

    sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .resetn(resetn), .d(spi_cs_n), .q(cs_s)
    );

    // One-cycle delayed copies of the synchronised strobes for edge detection
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    // Frame FSM: shifting, length check, and the registered broadcast outputs.
    // The check result is staged one cycle so fields and valid appear together.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state            <= SRX_IDLE;
            shift_reg        <= '0;
            bit_cnt          <= '0;
            chk_ok           <= 1'b0;
            chk_err          <= 1'b0;
            spi_cmd_r        <= '0;
            spi_addr_r       <= '0;
            spi_data_r       <= '0;
            spi_data_valid_r <= 1'b0;
            frame_err        <= 1'b0;
            busy             <= 1'b0;
        end else begin
            spi_data_valid_r <= 1'b0;
            frame_err        <= 1'b0;
            chk_ok           <= 1'b0;
            chk_err          <= 1'b0;

            if (chk_ok) begin
                spi_cmd_r        <= shift_reg[SPI_CMD_MSB:SPI_CMD_LSB];
                spi_addr_r       <= shift_reg[SPI_ADDR_MSB:SPI_ADDR_LSB];
                spi_data_r       <= shift_reg[SPI_DATA_MSB:SPI_DATA_LSB];
                spi_data_valid_r <= 1'b1;
            end
            if (chk_err) begin
                frame_err <= 1'b1;
            end

            case (state)
                SRX_IDLE: begin
                    if (cs_fall) begin
                        bit_cnt <= '0;
                        state   <= SRX_SHIFT;
                        busy    <= 1'b1;
                    end
                end
                SRX_SHIFT: begin
                    // CS release wins over a coincident SCLK edge
                    if (cs_rise) begin
                        state <= SRX_CHECK;
                        busy  <= 1'b0;
                    end else if (sclk_rise) begin
                        shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_s};
                        if (bit_cnt != CNT_MAX) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                SRX_CHECK: begin
                    chk_ok  <= (bit_cnt == CNT_FULL);
                    chk_err <= (bit_cnt != CNT_FULL);
                    state   <= SRX_IDLE;
                end
                default: begin
                    state <= SRX_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_rx.sv
// tb/tb_spi_cmd_rx.sv - directed self-checking bench for spi_cmd_rx
module tb_spi_cmd_rx;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic [15:0] spi_cmd_r;
    logic [7:0]  spi_addr_r;
    logic [39:0] spi_data_r;
    logic        spi_data_valid_r;
    logic        frame_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    logic [63:0] rx_q[$];

    always #5 clk = ~clk;

    spi_cmd_rx #(.SYNC_STAGES(SYNC), .FRAME_BITS(64)) dut (
        .clk(clk),
        .resetn(resetn),
        .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n),
        .spi_cmd_r(spi_cmd_r),
        .spi_addr_r(spi_addr_r),
        .spi_data_r(spi_data_r),
        .spi_data_valid_r(spi_data_valid_r),
        .frame_err(frame_err),
        .busy(busy)
    );

    // Record every pulse seen on the bus, sampled away from the active edge
    always @(negedge clk) begin
        if (spi_data_valid_r) begin
            valid_cnt++;
            rx_q.push_back({spi_cmd_r, spi_addr_r, spi_data_r});
        end
        if (frame_err) err_cnt++;
        if (spi_data_valid_r && frame_err) both_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // SCLK = clk/8, mode 0: MOSI set while SCLK low, captured on the rise
    task automatic send_frame(input logic [63:0] f, input int n, input bit raise);
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            spi_mosi = (i < 64) ? f[63 - i] : 1'b0;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        if (raise) spi_cs_n = 1'b1;
    endtask

    typedef struct {
        logic [15:0] cmd;
        logic [7:0]  addr;
        logic [39:0] data;
        int          nbits;
        bit          ok;
    } vec_t;

    vec_t vecs[7];
    logic [63:0] hold;
    int v0, e0, lat, busy_hi;

    initial begin
        vecs[0] = '{16'hA5A5, 8'h12, 40'h12_3456_789A, 64, 1'b1};
        vecs[1] = '{16'hFFFF, 8'hFF, 40'hFF_FFFF_FFFF, 64, 1'b1};
        vecs[2] = '{16'h1111, 8'h22, 40'h00_0000_0033, 63, 1'b0};
        vecs[3] = '{16'h8001, 8'h80, 40'h80_0000_0001, 64, 1'b1};
        vecs[4] = '{16'h2222, 8'h33, 40'h00_0000_0044, 65, 1'b0};
        vecs[5] = '{16'hABCD, 8'h07, 40'hCA_FE00_BEEF, 64, 1'b1};
        vecs[6] = '{16'h5555, 8'h01, 40'h00_0000_0001, 1,  1'b0};

        resetn   = 1'b0;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_fields", {spi_cmd_r, spi_addr_r, spi_data_r}, 64'h0);
        check("reset_pulses", {62'h0, spi_data_valid_r, frame_err}, 64'h0);
        check("reset_busy", {63'h0, busy}, 64'h0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        // Nominal frame with latency measurement from the CS pin rise
        v0 = valid_cnt; e0 = err_cnt;
        send_frame({16'h0123, 8'h04, 40'h00_0000_0003}, 64, 1'b0);
        spi_cs_n = 1'b1;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (spi_data_valid_r) begin
                lat = c;
                break;
            end
        end
        check("nominal_latency", 64'(lat), 64'(SYNC + 3));
        check("nominal_fields", {spi_cmd_r, spi_addr_r, spi_data_r}, {16'h0123, 8'h04, 40'h00_0000_0003});
        @(posedge clk); #1;
        check("nominal_one_cycle", {63'h0, spi_data_valid_r}, 64'h0);
        repeat (10) @(negedge clk);
        check("nominal_valid_cnt", 64'(valid_cnt - v0), 64'd1);
        check("nominal_err_cnt", 64'(err_cnt - e0), 64'd0);
        hold = {16'h0123, 8'h04, 40'h00_0000_0003};

        // Table of good, short and long frames
        for (int k = 0; k < 7; k++) begin
            v0 = valid_cnt; e0 = err_cnt;
            send_frame({vecs[k].cmd, vecs[k].addr, vecs[k].data}, vecs[k].nbits, 1'b1);
            repeat (15) @(negedge clk);
            if (vecs[k].ok) hold = {vecs[k].cmd, vecs[k].addr, vecs[k].data};
            check($sformatf("vec%0d_valid", k), 64'(valid_cnt - v0), vecs[k].ok ? 64'd1 : 64'd0);
            check($sformatf("vec%0d_err", k), 64'(err_cnt - e0), vecs[k].ok ? 64'd0 : 64'd1);
            check($sformatf("vec%0d_fields", k), {spi_cmd_r, spi_addr_r, spi_data_r}, hold);
        end

        // Back-to-back frames with CS high for 3 clk in between
        rx_q.delete();
        v0 = valid_cnt; e0 = err_cnt;
        send_frame({16'h1234, 8'h05, 40'h11_2233_4455}, 64, 1'b1);
        repeat (3) @(negedge clk);
        send_frame({16'h4321, 8'h06, 40'h55_4433_2211}, 64, 1'b1);
        repeat (15) @(negedge clk);
        check("b2b_valid_cnt", 64'(valid_cnt - v0), 64'd2);
        check("b2b_err_cnt", 64'(err_cnt - e0), 64'd0);
        check("b2b_first", (rx_q.size() > 0) ? rx_q[0] : 64'hX, {16'h1234, 8'h05, 40'h11_2233_4455});
        check("b2b_second", (rx_q.size() > 1) ? rx_q[1] : 64'hX, {16'h4321, 8'h06, 40'h55_4433_2211});

        // Reset after 30 bits of a frame
        v0 = valid_cnt; e0 = err_cnt;
        send_frame({16'hDEAD, 8'h09, 40'h00_BEEF_0000}, 30, 1'b0);
        check("midframe_busy", {63'h0, busy}, 64'h1);
        resetn   = 1'b0;
        spi_cs_n = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        check("rst_fields", {spi_cmd_r, spi_addr_r, spi_data_r}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        repeat (15) @(negedge clk);
        check("rst_no_valid", 64'(valid_cnt - v0), 64'd0);
        check("rst_no_err", 64'(err_cnt - e0), 64'd0);
        send_frame({16'hC0DE, 8'h0A, 40'h01_0203_0405}, 64, 1'b1);
        repeat (15) @(negedge clk);
        check("rst_next_valid", 64'(valid_cnt - v0), 64'd1);
        check("rst_next_fields", {spi_cmd_r, spi_addr_r, spi_data_r}, {16'hC0DE, 8'h0A, 40'h01_0203_0405});

        // SCLK noise with CS deasserted
        v0 = valid_cnt; e0 = err_cnt;
        busy_hi = 0;
        for (int t = 0; t < 10; t++) begin
            spi_mosi = 1'($urandom);
            spi_sclk = ~spi_sclk;
            for (int w = 0; w < 4; w++) begin
                @(negedge clk);
                if (busy) busy_hi++;
            end
        end
        repeat (10) @(negedge clk);
        check("noise_valid", 64'(valid_cnt - v0), 64'd0);
        check("noise_err", 64'(err_cnt - e0), 64'd0);
        check("noise_busy", 64'(busy_hi), 64'd0);

        check("never_both", 64'(both_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end of test, expected completion");
        $fatal(1);
    end

endmodule
